// File: rtl/stepper_pkg.sv
// Shared types and helpers for the stepper position controller: FSM states,
// the eight-entry coil phase table and the phase-index stepping rule.
package stepper_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // Coil patterns ordered {A1, B1, A2, B2}. Odd entries are the two-coil
    // full-step patterns; even entries are the single-coil half-step patterns.
    localparam logic [3:0] PHASE_TABLE [8] = '{
        4'b1000, 4'b1100, 4'b0100, 4'b0110,
        4'b0010, 4'b0011, 4'b0001, 4'b1001
    };

    // Advance the phase index one step in the given direction. Full mode
    // moves by two and always lands on an odd entry, even if the index it
    // starts from was left even by an earlier half-step move.
    function automatic logic [2:0] next_index(
        input logic [2:0] index,
        input logic       up,
        input logic       half
    );
        logic [2:0] base;
        logic [2:0] stride;
        base   = half ? index : (index | 3'd1);
        stride = half ? 3'd1 : 3'd2;
        return up ? (base + stride) : (base - stride);
    endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Step-rate divider: emits a one-clock tick every max(period,1) clocks.
// The period is sampled at reset and at each wrap, so a change only takes
// effect once the current interval has completed.
module step_tick_gen #(
    parameter int PERIOD_W = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] count;
    logic [PERIOD_W-1:0] limit;
    logic [PERIOD_W-1:0] period_eff;

    // A programmed period of zero behaves as one clock per tick.
    assign period_eff = (period == '0) ? ONE : period;

    // limit is never zero, so limit - 1 cannot underflow.
    assign tick = (count == (limit - ONE));

    // Free-running counter; the interval length is refreshed only on wrap.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register here samples the
        // values that existed before this clock edge.
        if (reset) begin
            count <= '0;
            limit <= period_eff;
        end else if (tick) begin
            count <= '0;
            limit <= period_eff;
        end else begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/stepper_position_ctrl.sv
// Closed-count position controller for one bipolar stepper. Steps the coil
// phase toward a signed absolute target at the programmed tick rate, then
// keeps the coils energised for a settle interval before pulsing done.
module stepper_position_ctrl
    import stepper_pkg::*;
#(
    parameter int POS_W        = 14,
    parameter int PERIOD_W     = 20,
    parameter int SETTLE_TICKS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                load,
    input  logic [POS_W-1:0]    target,
    input  logic [PERIOD_W-1:0] period,
    input  logic                half_step,
    input  logic                hold,
    input  logic                zero_pos,
    output logic                A1,
    output logic                B1,
    output logic                A2,
    output logic                B2,
    output logic [POS_W-1:0]    position,
    output logic                dir,
    output logic                busy,
    output logic                done
);

    localparam int                SET_W       = (SETTLE_TICKS < 2) ? 1 : $clog2(SETTLE_TICKS);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_TICKS - 1);
    localparam logic [SET_W-1:0]  SET_ONE     = SET_W'(1);
    localparam logic [POS_W-1:0]  POS_ONE     = POS_W'(1);

    state_t             state;
    logic [POS_W-1:0]   target_q;
    logic [2:0]         index;
    logic               mode_half;
    logic [SET_W-1:0]   settle_cnt;
    logic [3:0]         coils;
    logic               tick;

    logic signed [POS_W:0] diff;
    logic                  diff_zero;
    logic                  step_up;
    logic [2:0]            step_index;
    logic [2:0]            idle_index;
    logic [POS_W-1:0]      idle_pos;

    step_tick_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .period (period),
        .tick   (tick)
    );

    // One extra bit of headroom makes the signed difference overflow-free.
    assign diff       = $signed({target_q[POS_W-1], target_q}) - $signed({position[POS_W-1], position});
    assign diff_zero  = (diff == '0);
    assign step_up    = ~diff[POS_W];
    assign step_index = next_index(index, step_up, mode_half);

    // While idle, selecting full mode snaps the index onto an odd pattern.
    assign idle_index = half_step ? index : (index | 3'd1);
    // A same-cycle zero_pos is already applied when a new target is compared.
    assign idle_pos   = zero_pos ? '0 : position;

    assign {A1, B1, A2, B2} = coils;

    // Motion FSM: position, phase index, coil pattern and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            position   <= '0;
            target_q   <= '0;
            index      <= 3'd1;
            mode_half  <= 1'b0;
            settle_cnt <= '0;
            coils      <= 4'b0000;
            dir        <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            // The target register follows load in every state; a tick in the
            // same cycle still compares against the previous target.
            if (load) begin
                target_q <= target;
            end

            case (state)
                IDLE: begin
                    mode_half <= half_step;
                    if (zero_pos) begin
                        position <= '0;
                    end
                    if (en) begin
                        index <= idle_index;
                    end
                    if (load && (target != idle_pos)) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        if (en) begin
                            coils <= PHASE_TABLE[idle_index];
                        end
                    end else if (en) begin
                        coils <= hold ? PHASE_TABLE[idle_index] : 4'b0000;
                    end
                end

                RUN: begin
                    if (en && tick) begin
                        if (!diff_zero) begin
                            dir      <= step_up;
                            position <= step_up ? (position + POS_ONE) : (position - POS_ONE);
                            index    <= step_index;
                            coils    <= PHASE_TABLE[step_index];
                        end else begin
                            state      <= SETTLE;
                            settle_cnt <= '0;
                            coils      <= PHASE_TABLE[index];
                        end
                    end else if (en) begin
                        coils <= PHASE_TABLE[index];
                    end
                end

                SETTLE: begin
                    // A new target abandons the settle with no done pulse.
                    if (load && (target != position)) begin
                        state      <= RUN;
                        settle_cnt <= '0;
                    end else if (en && tick) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            coils <= hold ? PHASE_TABLE[index] : 4'b0000;
                        end else begin
                            settle_cnt <= settle_cnt + SET_ONE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
